// File: rtl/sa_ws_if.sv
// Handshake bundle for sa_ws_array: weight row beats and activation vectors in,
// deskewed result vectors out, plus the weight-load FSM state for observation.
interface sa_ws_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 16,
  parameter int AW   = 32
);
  // valid/ready: a beat transfers on the rising edge where valid && ready are both high;
  // ready never depends on data. out_valid has no ready: the consumer takes every pulse.
  logic               w_valid;
  logic               w_ready;
  logic [COLS*DW-1:0] w_row;
  logic               w_loaded;
  logic               a_valid;
  logic               a_ready;
  logic [ROWS*DW-1:0] a_vec;
  logic               out_valid;
  logic [COLS*AW-1:0] out_psum;
  logic [1:0]         state_dbg;

  modport master (
    output w_valid, w_row, a_valid, a_vec,
    input  w_ready, w_loaded, a_ready, out_valid, out_psum, state_dbg
  );

  modport slave (
    input  w_valid, w_row, a_valid, a_vec,
    output w_ready, w_loaded, a_ready, out_valid, out_psum, state_dbg
  );
endinterface

// File: rtl/sa_ws_array.sv
// Weight-stationary ROWS x COLS signed MAC array with weight-load FSM, input skew,
// output deskew and a valid pipeline; one aligned result vector per accepted input.
module sa_ws_array #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 16,
  parameter int AW   = 32
) (
  input logic   clk,
  input logic   rst,
  sa_ws_if.slave bus
);
  localparam int LAT = ROWS + COLS - 1;
  localparam int CW  = $clog2(ROWS + 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [LAT-1:0] vld_q;
  logic           pipe_empty, w_ready_c, a_ready_c, w_fire, a_fire;

  assign pipe_empty = (vld_q == '0);
  // Reloading waits for an empty pipeline so every in-flight vector sees one weight set.
  assign w_ready_c  = (state_q != READY) || pipe_empty;
  assign a_ready_c  = (state_q == READY) && !(bus.w_valid && w_ready_c);
  assign w_fire     = bus.w_valid && w_ready_c;
  assign a_fire     = bus.a_valid && a_ready_c;

  assign bus.w_ready   = w_ready_c;
  assign bus.a_ready   = a_ready_c;
  assign bus.w_loaded  = (state_q == READY);
  assign bus.state_dbg = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= (vld_q << 1) | LAT'(a_fire);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      EMPTY, READY: begin
        if (w_fire) begin
          state_d = (ROWS == 1) ? READY : LOAD;
          cnt_d   = CW'(1);
        end
      end
      LOAD: begin
        if (w_fire) begin
          if (cnt_q == CW'(ROWS - 1)) begin
            state_d = READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = EMPTY;
        cnt_d   = '0;
      end
    endcase
  end

  logic signed [DW-1:0] lane_in [ROWS];
  logic signed [DW-1:0] w_w     [ROWS][COLS];
  logic signed [DW-1:0] act_w   [ROWS][COLS];
  logic signed [AW-1:0] psum_w  [ROWS][COLS];

  // Lane r is delayed r cycles so it meets the psum wavefront coming down column 0.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic signed [DW-1:0] a_lane;
    assign a_lane = a_fire ? $signed(bus.a_vec[r*DW +: DW]) : '0;
    if (r == 0) begin : g_direct
      assign lane_in[r] = a_lane;
    end else begin : g_delay
      logic signed [DW-1:0] sk_q [r];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < r; k++) sk_q[k] <= '0;
        end else begin
          sk_q[0] <= a_lane;
          for (int k = 1; k < r; k++) sk_q[k] <= sk_q[k-1];
        end
      end
      assign lane_in[r] = sk_q[r-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_cell
      logic signed [DW-1:0]   w_q, act_q, w_src, act_src;
      logic signed [AW-1:0]   psum_q, psum_src;
      logic signed [2*DW-1:0] prod;

      if (r == 0) begin : g_top
        assign w_src    = $signed(bus.w_row[c*DW +: DW]);
        assign psum_src = '0;
      end else begin : g_inner
        assign w_src    = w_w[r-1][c];
        assign psum_src = psum_w[r-1][c];
      end

      if (c == 0) begin : g_left
        assign act_src = lane_in[r];
      end else begin : g_mid
        assign act_src = act_w[r][c-1];
      end

      assign prod = act_src * w_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          w_q    <= '0;
          act_q  <= '0;
          psum_q <= '0;
        end else begin
          if (w_fire) w_q <= w_src;
          act_q  <= act_src;
          psum_q <= psum_src + AW'(prod);
        end
      end

      assign w_w[r][c]    = w_q;
      assign act_w[r][c]  = act_q;
      assign psum_w[r][c] = psum_q;
    end
  end

  logic [COLS*AW-1:0] aligned, hold_q;

  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_pass
      assign aligned[c*AW +: AW] = psum_w[ROWS-1][c];
    end else begin : g_delay
      logic [AW-1:0] dk_q [D];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < D; k++) dk_q[k] <= '0;
        end else begin
          dk_q[0] <= psum_w[ROWS-1][c];
          for (int k = 1; k < D; k++) dk_q[k] <= dk_q[k-1];
        end
      end
      assign aligned[c*AW +: AW] = dk_q[D-1];
    end
  end

  // Between results the output shows the last valid vector, not the bubble contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else if (vld_q[LAT-1]) hold_q <= aligned;
  end

  assign bus.out_valid = vld_q[LAT-1];
  assign bus.out_psum  = vld_q[LAT-1] ? aligned : hold_q;
endmodule

// File: tb/tb_sa_ws_array.sv
// Bench for sa_ws_array: a directed 2x2 sequence plus table-driven and random streams
// on a 4x4 instance, checked through an expected-result queue with latency tracking.
module tb_sa_ws_array;
  localparam int R = 4, C = 4, DW = 16, AW = 32, LAT = R + C - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, last_acc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sa_ws_if #(.ROWS(R), .COLS(C), .DW(DW), .AW(AW)) bus4 ();
  sa_ws_if #(.ROWS(2), .COLS(2), .DW(DW), .AW(AW)) bus2 ();

  sa_ws_array #(.ROWS(R), .COLS(C), .DW(DW), .AW(AW)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  sa_ws_array #(.ROWS(2), .COLS(2), .DW(DW), .AW(AW)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  task automatic chk(input string name, input logic [C*AW-1:0] act, input logic [C*AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [C*AW-1:0] exp_q[$];
  int              acc_q[$];
  logic [C*AW-1:0] last_out, sb_e;
  int              sb_t;

  always @(negedge clk) begin
    if (rst) begin
      last_out = '0;
    end else if (bus4.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        sb_e = exp_q.pop_front();
        sb_t = acc_q.pop_front();
        chk("out_psum", bus4.out_psum, sb_e);
        chk("latency", cyc - sb_t, LAT);
        last_out = sb_e;
      end
    end else begin
      chk("out_psum_hold", bus4.out_psum, last_out);
    end
  end

  // ---------------- model ----------------
  logic signed [DW-1:0] wm [R][C];

  function automatic logic [C*AW-1:0] model(input logic [R*DW-1:0] a);
    logic [C*AW-1:0] res;
    logic [AW-1:0]   acc;
    longint          p;
    for (int c = 0; c < C; c++) begin
      acc = '0;
      for (int r = 0; r < R; r++) begin
        p   = longint'($signed(a[r*DW +: DW])) * longint'(wm[r][c]);
        acc = acc + AW'(p);
      end
      res[c*AW +: AW] = acc;
    end
    return res;
  endfunction

  function automatic logic [C*AW-1:0] sext_vec(input logic [R*DW-1:0] a);
    logic [C*AW-1:0] res;
    for (int i = 0; i < C; i++) res[i*AW +: AW] = {{(AW-DW){a[i*DW+DW-1]}}, a[i*DW +: DW]};
    return res;
  endfunction

  // Beat k carries the row that ends up at index R-1-k.
  function automatic logic [C*DW-1:0] beat_row(input int k);
    logic [C*DW-1:0] row;
    for (int c = 0; c < C; c++) row[c*DW +: DW] = wm[R-1-k][c];
    return row;
  endfunction

  // ---------------- drivers (entered and left at posedge+1) ----------------
  task automatic load_beat(input int k, input bit with_a);
    int n = 0;
    bus4.w_valid = 1'b1;
    bus4.w_row   = beat_row(k);
    if (with_a) begin
      bus4.a_valid = 1'b1;
      bus4.a_vec   = {$urandom, $urandom};
    end
    @(negedge clk);
    while (!bus4.w_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("w_ready_wait", n >= 100, 0);
    if (with_a) chk("a_ready_blocked", bus4.a_ready, 0);
    @(posedge clk); #1;
    bus4.w_valid = 1'b0;
    bus4.a_valid = 1'b0;
  endtask

  task automatic load_matrix(input bit with_a);
    for (int k = 0; k < R; k++) begin
      load_beat(k, with_a);
      chk("w_loaded", bus4.w_loaded, k == R - 1);
    end
  endtask

  task automatic send_vec(input bit v, input logic [R*DW-1:0] a, input logic [C*AW-1:0] e);
    int n = 0;
    bus4.a_valid = v;
    bus4.a_vec   = a;
    @(negedge clk);
    if (v) begin
      while (!bus4.a_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("a_ready", bus4.a_ready, 1);
      exp_q.push_back(e);
      acc_q.push_back(cyc);
      last_acc = cyc;
    end
    @(posedge clk); #1;
    bus4.a_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic rand_weights();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wm[r][c] = DW'($urandom);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_w_loaded"}, bus4.w_loaded, 0);
    chk({tag, "_out_valid"}, bus4.out_valid, 0);
    chk({tag, "_out_psum"}, bus4.out_psum, 0);
    chk({tag, "_a_ready"}, bus4.a_ready, 0);
    chk({tag, "_w_ready"}, bus4.w_ready, 1);
  endtask

  typedef struct {
    bit              v;
    logic [R*DW-1:0] a;
    logic [C*AW-1:0] e;
  } vec_t;
  vec_t tbl [9];
  logic [R*DW-1:0] ra;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0] = '{1'b1, 64'hFFFF_0001_8000_7FFF, 128'hFFFFFFFF_00000001_FFFF8000_00007FFF};
    tbl[1] = '{1'b1, 64'h0000_0000_0000_0000, 128'h0};
    tbl[2] = '{1'b1, 64'h1234_FEDC_0042_8001, 128'h00001234_FFFFFEDC_00000042_FFFF8001};
    for (int i = 3; i < 9; i++) begin
      tbl[i].v = (i != 5);
      tbl[i].a = {$urandom, $urandom};
      tbl[i].e = sext_vec(tbl[i].a);
    end

    bus4.w_valid = 0; bus4.w_row = '0; bus4.a_valid = 0; bus4.a_vec = '0;
    bus2.w_valid = 0; bus2.w_row = '0; bus2.a_valid = 0; bus2.a_vec = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset4");
    chk("reset4_state", bus4.state_dbg, 0);
    chk("reset2_w_ready", bus2.w_ready, 1);
    chk("reset2_out_psum", bus2.out_psum, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 2x2: beats [3,4] then [1,2], a=[5,6] -> [23,34] three cycles later
    bus2.w_valid = 1'b1;
    bus2.w_row   = {16'd4, 16'd3};
    @(negedge clk); chk("2x2_w_ready", bus2.w_ready, 1);
    @(posedge clk); #1;
    bus2.w_row = {16'd2, 16'd1};
    @(negedge clk); chk("2x2_w_loaded_early", bus2.w_loaded, 0);
    @(posedge clk); #1;
    bus2.w_valid = 1'b0;
    @(negedge clk); chk("2x2_w_loaded", bus2.w_loaded, 1);
    @(posedge clk); #1;
    bus2.a_valid = 1'b1;
    bus2.a_vec   = {16'd6, 16'd5};
    @(negedge clk); chk("2x2_a_ready", bus2.a_ready, 1);
    @(posedge clk); #1;
    bus2.a_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("2x2_out_valid", bus2.out_valid, i == 3);
      if (i >= 3) chk("2x2_out_psum", bus2.out_psum, {32'd34, 32'd23});
    end
    @(posedge clk); #1;

    // activations in EMPTY are refused
    for (int i = 0; i < 4; i++) begin
      bus4.a_valid = 1'b1;
      bus4.a_vec   = {$urandom, $urandom};
      @(negedge clk); chk("empty_a_ready", bus4.a_ready, 0);
      @(posedge clk); #1;
    end
    bus4.a_valid = 1'b0;

    // identity weights, loaded with a_valid held high (refused in EMPTY/LOAD)
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wm[r][c] = (r == c) ? 16'sd1 : 16'sd0;
    load_matrix(1'b1);
    for (int i = 0; i < 9; i++) send_vec(tbl[i].v, tbl[i].a, tbl[i].e);
    drain();

    // all -32768: each lane 4*2^30 wraps to 0; reload starts with a_valid also high
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wm[r][c] = 16'sh8000;
    load_matrix(1'b1);
    send_vec(1'b1, 64'h8000_8000_8000_8000, 128'h0);
    send_vec(1'b1, 64'h8000_8000_8000_8000, 128'h0);
    drain();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wm[r][c] = 16'sd1;
    load_matrix(1'b0);
    send_vec(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, {4{32'hFFFF_FFFC}});
    drain();

    // random weights and vectors, then a reload held off by in-flight results
    rand_weights();
    load_matrix(1'b0);
    for (int i = 0; i < 5; i++) begin
      ra = {$urandom, $urandom};
      send_vec(1'b1, ra, model(ra));
    end
    rand_weights();
    bus4.w_valid = 1'b1;
    bus4.w_row   = beat_row(0);
    n = 0;
    do begin
      @(negedge clk);
      chk("w_ready_backpressure", bus4.w_ready, cyc > last_acc + LAT);
      n++;
    end while (!bus4.w_ready && n < 40);
    @(posedge clk); #1;
    bus4.w_valid = 1'b0;
    chk("reload_w_loaded", bus4.w_loaded, 0);
    for (int k = 1; k < R; k++) begin
      load_beat(k, 1'b0);
      chk("reload_w_loaded", bus4.w_loaded, k == R - 1);
    end
    for (int i = 0; i < 4; i++) begin
      ra = {$urandom, $urandom};
      send_vec(1'b1, ra, model(ra));
    end
    drain();

    // reset in the middle of a load
    rand_weights();
    load_beat(0, 1'b0);
    load_beat(1, 1'b0);
    #2 rst = 1'b1;
    #1 check_cleared("rst_mid_load");
    @(posedge clk); #1;
    rst = 1'b0;

    // reset with results in flight: nothing may come out afterwards
    load_matrix(1'b0);
    for (int i = 0; i < 3; i++) begin
      ra = {$urandom, $urandom};
      send_vec(1'b1, ra, model(ra));
    end
    @(posedge clk); #3;
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    #1 check_cleared("rst_mid_stream");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;

    // fresh load and compute after reset
    rand_weights();
    load_matrix(1'b0);
    for (int i = 0; i < 4; i++) begin
      ra = {$urandom, $urandom};
      send_vec(i != 2, ra, model(ra));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sa_ws_array.md
Name: sa_ws_array

Overview:
- Parametrised weight-stationary systolic array of ROWS x COLS multiply-accumulate cells, for signed matrix-vector streaming.
- Carries its own control around the grid:
  - weight-load FSM
  - activation input skew
  - output deskew
  - valid/ready handshakes
- Delivers one fully aligned COLS-wide result vector per accepted activation vector.
- Replaces fixed-size hand-wired PE grids in the accelerator datapath.

Parameters:
ROWS, 4, number of PE rows (activation lanes / reduction depth), >=1
COLS, 4, number of PE columns (output lanes), >=1
DW, 16, signed width of activations and weights
AW, 32, signed width of partial sums / outputs (AW >= 2*DW)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
w_valid  in  1  weight row beat valid
w_ready  out  1  weight beat accepted when w_valid&&w_ready
w_row  in  COLS*DW  one weight row, lane c at [c*DW +: DW]
w_loaded  out  1  full weight matrix resident
a_valid  in  1  activation vector valid
a_ready  out  1  activation accepted when a_valid&&a_ready
a_vec  in  ROWS*DW  activation vector, lane r at [r*DW +: DW]
out_valid  out  1  result vector valid (single-cycle pulse per input vector)
out_psum  out  COLS*AW  result, lane c at [c*AW +: AW]

Behaviour:
- Reset (async, any time, including mid-load or mid-stream):
  - state=EMPTY; all weight, activation, psum, skew, deskew and valid-pipeline registers = 0.
  - w_loaded=0, out_valid=0, out_psum=0, a_ready=0, w_ready=1.
- FSM states: EMPTY, LOAD, READY.
  - EMPTY: w_ready=1, a_ready=0. An accepted beat goes to LOAD with beat count=1, or straight to READY if ROWS==1.
  - LOAD: w_ready=1, a_ready=0. Each accepted beat increments the count. The beat that makes count==ROWS moves to READY and sets w_loaded=1 in the next cycle. Idle cycles (w_valid=0) keep state.
  - READY: a_ready = !(w_valid && w_ready).
    - w_ready = 1 only when the valid pipeline is empty (no result still in flight).
    - An accepted weight beat clears w_loaded and goes to LOAD with count=1 (or stays READY if ROWS==1, with weights replaced).
    - Simultaneous w_valid and a_valid with pipeline empty: the weight beat wins; the activation is not accepted.
- Weight loading: the column shift chain moves weights down one row per accepted beat; the new w_row enters row 0.
  - After ROWS beats, beat k (0-based) sits in row ROWS-1-k. The first beat loaded is the bottom row.
  - Weights are held while no beat is accepted.
- Compute cell (r,c): registered act_out=act_in; registered psum_out = psum_in + sext(act_in)*sext(w[r][c]), taken modulo 2^AW (wrap, no saturation).
  - Row 0 psum_in = 0.
  - Activations move right one column per cycle; psums move down one row per cycle.
- Skew: lane r of an accepted a_vec enters column 0 of row r after r cycles of delay.
- Deskew: bottom-row column c output is delayed COLS-1-c cycles, so all lanes align.
- Latency: out_valid and out_psum for a vector accepted in cycle t are presented in cycle t+ROWS+COLS-1. out_psum[c] = sum over r of a[r]*W[r][c], where W is the weight matrix resident when the vector was accepted.
- Throughput: one vector per cycle. Bubbles (a_valid=0) propagate as invalid slots.
- No backpressure on the output: the consumer must accept every out_valid cycle.
- out_psum holds its last valid value when out_valid=0.
- a_valid while not READY is ignored; nothing enters the pipeline.

Test Plan:
- ROWS=COLS=2: load beats [3,4] then [1,2]; send a=[5,6] -> 3 cycles later out_valid=1, out_psum=[23,34]; w_loaded=1 from the cycle after beat 2.
- Default 4x4, identity weights, stream 8 back-to-back vectors including one a_valid=0 bubble -> 8 results at latency 7 with one gap, each output equal to its input sign-extended to 32 bits.
- 4x4, all weights and activations = -32768 -> each lane = 4*2^30, which wraps to 0; all-ones weights with a=[-1,-1,-1,-1] -> -4 per lane.
- Hold w_valid high while results are in flight -> w_ready=0 until the last out_valid, then the reload proceeds. Simultaneous a_valid and w_valid on an empty pipeline -> the weight beat is accepted, the activation is not.
- Assert rst mid-LOAD (beat 2 of 4) and mid-stream -> outputs and w_loaded clear immediately; no out_valid after reset; a fresh load and compute gives correct results.
- a_valid asserted in EMPTY/LOAD -> a_ready=0, no out_valid ever produced for those cycles.
